// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: widths, state encoding, zero index
// and the decode-stage destination mux.
package reg_bank_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Decode-stage destination select: R-type writes rd, I-type writes rt.
  function automatic logic [ADDR_W-1:0] f_dest_sel(
    input logic              reg_dst,
    input logic [ADDR_W-1:0] rt_idx,
    input logic [ADDR_W-1:0] rd_idx
  );
    return reg_dst ? rd_idx : rt_idx;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Register bank bus: write port, two read ports, HI/LO pair, busy and debug state.
// Handshake: no valid/ready; wr_en/hilo_wr are single-cycle strobes honoured only while busy=0.
interface reg_bank_if;
  import reg_bank_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] rd_select;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              hilo_wr;
  logic [DATA_W-1:0] hi_in;
  logic [DATA_W-1:0] lo_in;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              busy;
  state_e            state;

  modport master (
    output wr_en, rd_select, wr_data, rs_addr, rt_addr, hilo_wr, hi_in, lo_in,
    input  rs_data, rt_data, hi_out, lo_out, busy, state
  );

  modport slave (
    input  wr_en, rd_select, wr_data, rs_addr, rt_addr, hilo_wr, hi_in, lo_in,
    output rs_data, rt_data, hi_out, lo_out, busy, state
  );

endinterface

// File: rtl/reg_bank_clear.sv
// Post-reset clear engine: walks every register index once, one per cycle,
// then parks in READY.
module reg_bank_clear
  import reg_bank_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output state_e            o_state
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Counter holds at the last index on the exit cycle so it never wraps.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    o_busy        = 1'b0;
    o_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        if (r_clr_cnt == ADDR_W'(NREGS - 1)) begin
          w_state_nxt = ST_READY;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign o_clr_addr = r_clr_cnt;
  assign o_state    = r_state;

endmodule

// File: rtl/reg_bank.sv
// General-purpose register file with HI/LO pair and post-reset clear.
// Optional macro REG_BANK_WRITE_FORWARD_EN forwards same-cycle GPR writes to the read ports.
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_fire;
  logic              w_hilo_fire;
  logic [DATA_W-1:0] w_rs_stored;
  logic [DATA_W-1:0] w_rt_stored;

  // Index 0 has no storage; it is hardwired to zero on the read side.
  logic [DATA_W-1:0] r_regs [1:NREGS-1];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  reg_bank_clear u_clear (
    .i_clk      (clock),
    .i_rst      (reset),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_state    (bus.state)
  );

  assign w_wr_fire   = !w_busy && bus.wr_en && (bus.rd_select != REG_ZERO);
  assign w_hilo_fire = !w_busy && bus.hilo_wr;

  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      if (w_clr_addr != REG_ZERO) r_regs[w_clr_addr] <= '0;
    end else if (w_wr_fire) begin
      r_regs[bus.rd_select] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_hilo_fire) begin
      r_hi <= bus.hi_in;
      r_lo <= bus.lo_in;
    end
  end

  assign w_rs_stored = (bus.rs_addr == REG_ZERO) ? '0 : r_regs[bus.rs_addr];
  assign w_rt_stored = (bus.rt_addr == REG_ZERO) ? '0 : r_regs[bus.rt_addr];

  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (!w_busy) begin
`ifdef REG_BANK_WRITE_FORWARD_EN
      bus.rs_data = (w_wr_fire && bus.rs_addr == bus.rd_select) ? bus.wr_data : w_rs_stored;
      bus.rt_data = (w_wr_fire && bus.rt_addr == bus.rd_select) ? bus.wr_data : w_rt_stored;
`else
      bus.rs_data = w_rs_stored;
      bus.rt_data = w_rt_stored;
`endif
    end
  end

  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;
  assign bus.busy   = w_busy;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_reg_bank;

  logic clock;
  logic reset;

  reg_bank_if bus_if ();

  reg_bank dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors;
  int checks;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.wr_en     = 1'b0;
    bus_if.rd_select = '0;
    bus_if.wr_data   = '0;
    bus_if.rs_addr   = '0;
    bus_if.rt_addr   = '0;
    bus_if.hilo_wr   = 1'b0;
    bus_if.hi_in     = '0;
    bus_if.lo_in     = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endtask

  // Model view of a read port during READY for the currently driven inputs.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_regs[a];
`ifdef REG_BANK_WRITE_FORWARD_EN
    if (bus_if.wr_en && bus_if.rd_select != 5'd0 && bus_if.rd_select == a) v = bus_if.wr_data;
`endif
    return v;
  endfunction

  // Commit the currently driven inputs into the model (READY only).
  task automatic model_commit();
    if (bus_if.wr_en && bus_if.rd_select != 5'd0) m_regs[bus_if.rd_select] = bus_if.wr_data;
    if (bus_if.hilo_wr) begin
      m_hi = bus_if.hi_in;
      m_lo = bus_if.lo_in;
    end
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'd32);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus_if.rs_addr = 5'(i);
      bus_if.rt_addr = 5'(31 - i);
      #1;
      check({tag, "_rs"}, bus_if.rs_data, model_read(5'(i)));
      check({tag, "_rt"}, bus_if.rt_data, model_read(5'(31 - i)));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    drive_idle();
    model_clear();
    reset = 1'b1;

    // 1. reset for 3 cycles, then clear runs for exactly 32 cycles
    repeat (3) tick();
    check("busy_in_reset", {31'd0, bus_if.busy}, 32'd1);
    check("hi_reset", bus_if.hi_out, 32'd0);
    check("lo_reset", bus_if.lo_out, 32'd0);
    reset = 1'b0;
    wait_clear("busy_len_1");
    check("busy_low_1", {31'd0, bus_if.busy}, 32'd0);
    check_all_regs("post_clear");
    check("hi_post_clear", bus_if.hi_out, 32'd0);
    check("lo_post_clear", bus_if.lo_out, 32'd0);

    // 2. write reg5 and check same-cycle and next-cycle reads
    bus_if.wr_en = 1'b1; bus_if.rd_select = 5'd5; bus_if.wr_data = 32'hDEADBEEF;
    bus_if.rs_addr = 5'd5; bus_if.rt_addr = 5'd5;
    #1;
`ifdef REG_BANK_WRITE_FORWARD_EN
    check("same_cycle_rs5", bus_if.rs_data, 32'hDEADBEEF);
`else
    check("same_cycle_rs5", bus_if.rs_data, 32'd0);
`endif
    model_commit();
    tick();
    bus_if.wr_en = 1'b0;
    #1;
    check("next_cycle_rs5", bus_if.rs_data, 32'hDEADBEEF);
    check("next_cycle_rt5", bus_if.rt_data, 32'hDEADBEEF);

    // 3. write to index 0 is dropped
    bus_if.wr_en = 1'b1; bus_if.rd_select = 5'd0; bus_if.wr_data = 32'h12345678;
    bus_if.rs_addr = 5'd0; bus_if.rt_addr = 5'd0;
    #1;
    check("reg0_same_cycle", bus_if.rs_data, 32'd0);
    tick();
    bus_if.wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("reg0_rs", bus_if.rs_data, 32'd0);
      check("reg0_rt", bus_if.rt_data, 32'd0);
      tick();
    end

    // 4. HI/LO and GPR write in the same cycle
    bus_if.hilo_wr = 1'b1; bus_if.hi_in = 32'h1; bus_if.lo_in = 32'hFFFFFFFF;
    bus_if.wr_en = 1'b1; bus_if.rd_select = 5'd31; bus_if.wr_data = 32'hA5A5A5A5;
    bus_if.rs_addr = 5'd31;
    #1;
    check("hi_before_edge", bus_if.hi_out, 32'd0);
    model_commit();
    tick();
    drive_idle();
    bus_if.rs_addr = 5'd31;
    #1;
    check("hi_after", bus_if.hi_out, 32'h1);
    check("lo_after", bus_if.lo_out, 32'hFFFFFFFF);
    check("reg31_after", bus_if.rs_data, 32'hA5A5A5A5);

    // randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      bus_if.wr_en     = ($urandom_range(0, 1) == 1);
      bus_if.rd_select = 5'($urandom_range(0, 31));
      bus_if.wr_data   = $urandom;
      bus_if.rs_addr   = 5'($urandom_range(0, 31));
      bus_if.rt_addr   = ($urandom_range(0, 3) == 0) ? bus_if.rd_select : 5'($urandom_range(0, 31));
      bus_if.hilo_wr   = ($urandom_range(0, 3) == 0);
      bus_if.hi_in     = $urandom;
      bus_if.lo_in     = $urandom;
      #1;
      check("rand_rs", bus_if.rs_data, model_read(bus_if.rs_addr));
      check("rand_rt", bus_if.rt_data, model_read(bus_if.rt_addr));
      check("rand_hi", bus_if.hi_out, m_hi);
      check("rand_lo", bus_if.lo_out, m_lo);
      model_commit();
      tick();
    end
    drive_idle();
    #1;
    check_all_regs("post_rand");

    // 5. reset mid-clear restarts the sequence; writes during busy ignored
    bus_if.wr_en = 1'b1; bus_if.rd_select = 5'd7; bus_if.wr_data = 32'h55;
    tick();
    bus_if.wr_en = 1'b0; bus_if.rs_addr = 5'd7;
    #1;
    check("reg7_written", bus_if.rs_data, 32'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("busy_mid_clear", {31'd0, bus_if.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    bus_if.wr_en = 1'b1; bus_if.rd_select = 5'd7; bus_if.wr_data = 32'h99;
    bus_if.hilo_wr = 1'b1; bus_if.hi_in = 32'h77; bus_if.lo_in = 32'h88;
    bus_if.rs_addr = 5'd7;
    #1;
    check("rs_forced_zero_busy", bus_if.rs_data, 32'd0);
    wait_clear("busy_len_restart");
    drive_idle();
    bus_if.rs_addr = 5'd7;
    #1;
    check("reg7_after_restart", bus_if.rs_data, 32'd0);
    check("hi_after_restart", bus_if.hi_out, 32'd0);
    check("lo_after_restart", bus_if.lo_out, 32'd0);
    check_all_regs("post_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
